bf2_seq_ctrl: RTL and testbench
===============================

BF2_SEQ_CTRL -- requirements
Module: bf2_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: lanes per block, one index entry per lane.
REQ-002 Parameter N_BLOCKS, default 32: blocks per frame.
REQ-003 Parameter PIPE_LAT, default 2: cycles from valid_start_2 to the index consumer inside stage 2.
REQ-004 Parameter DRAIN_TIMEOUT, default 16: maximum DRAIN cycles before abort.
REQ-005 The clock port SHALL be `clk  in  1`: single clock, all logic on its rising edge.
REQ-006 The reset port SHALL be `rst  in  1`: reset is asynchronous and active-high.
REQ-007 `frame_start  in  1`: one-cycle pulse that arms a frame.
REQ-008 `in_valid  in  1`: upstream block valid, one block per asserted cycle.
REQ-009 `bf2_o_en  in  1`: stage-2 output valid, returned from the datapath.
REQ-010 `valid_start_2  out  1`: block launch into stage 2.
REQ-011 `index1_valid`, `index2_valid  out  1 each`: index-array qualifiers.
REQ-012 `index1`, `index2  out  [4:0] x DATA_WIDTH each`: per-lane twiddle indices.
REQ-013 `busy  out  1`: high whenever the state is not IDLE.
REQ-014 `frame_done  out  1`: one-cycle pulse when a frame completes.
REQ-015 `err_protocol  out  1`: one-cycle pulse on a protocol violation.
REQ-016 `err_timeout  out  1`: one-cycle pulse when DRAIN aborts.

Function
REQ-017 The FSM SHALL use four states, IDLE, RUN, DRAIN and DONE; the reset state is IDLE.
REQ-018 IDLE -> RUN on frame_start; blk_cnt and out_cnt clear to 0 on that transition.
REQ-019 In RUN, each cycle with in_valid=1 SHALL register valid_start_2=1 on the next cycle and increment blk_cnt.
- Gaps in in_valid are allowed; valid_start_2 stays 0 during gaps.
REQ-020 RUN -> DRAIN on the cycle that accepts the block with blk_cnt=N_BLOCKS-1.
REQ-021 For a block b launched at cycle t, index1_valid and index2_valid SHALL be 1 at cycle t+PIPE_LAT, with that block's index arrays.
REQ-022 Index formulas for lane k of block b:
- index1[k] = {b[1:0], k[3:1]}
- index2[k] = {b[4:2], k[1:0]}
REQ-023 When their valid is 0, index1 and index2 SHALL hold 0.
REQ-024 out_cnt SHALL increment on every bf2_o_en=1 while in RUN or DRAIN, saturating at N_BLOCKS.
REQ-025 DRAIN -> DONE when out_cnt reaches N_BLOCKS (including the same-cycle increment).
- DONE drives frame_done=1 for one cycle, then returns to IDLE.
REQ-026 If out_cnt has not reached N_BLOCKS after DRAIN_TIMEOUT DRAIN cycles: pulse err_timeout, go to IDLE, drop pending index pipe entries, no frame_done.
REQ-027 Any of the following SHALL pulse err_protocol for one cycle, with no other effect:
- in_valid=1 in IDLE, DRAIN or DONE (the block is not launched);
- frame_start=1 outside IDLE;
- bf2_o_en=1 in IDLE.
REQ-028 frame_start and in_valid in the same IDLE cycle: arm only; that in_valid is not accepted and flags err_protocol.
REQ-029 blk_cnt SHALL wrap from N_BLOCKS-1 to 0 and SHALL never exceed N_BLOCKS-1.
REQ-030 Outputs SHALL be registered; there is no combinational path from input to output.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, all counters=0, index pipe cleared.
- Outputs: valid_start_2, index1_valid, index2_valid, busy, frame_done, err_protocol, err_timeout = 0.
- All index1 and index2 entries = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no frame_done; after release, the next frame starts only on a new frame_start.

Structure
REQ-033 Package fft_ctrl_pkg SHALL hold:
- the state enum (IDLE/RUN/DRAIN/DONE);
- the IDX_W=5 constant;
- the default N_BLOCKS, PIPE_LAT and DRAIN_TIMEOUT constants.
REQ-034 A single sub-module, bf2_index_gen, SHALL compute the index arrays from b and delay them with the valid bit through a PIPE_LAT-deep register pipe.

Verification
REQ-035 Frame of 32 back-to-back in_valid with bf2_o_en looped back as valid_start_2 delayed 3 cycles -> 32 valid_start_2 pulses; exactly one frame_done, 4 cycles after the last launch.
REQ-036 Block b=13 -> two cycles after its launch:
- index1_valid=1 and index2_valid=1;
- index1[5]=5'b01010;
- index2[5]=5'b01101.
REQ-037 in_valid toggling 1,0,0,1 during RUN -> launches mirror it one cycle later; blk_cnt advances only on accepted blocks.
REQ-038 in_valid=1 in IDLE, and frame_start during RUN -> err_protocol pulses; no launch; frame continues unaffected.
REQ-039 Only 30 bf2_o_en returned -> err_timeout exactly 16 DRAIN cycles after entering DRAIN; state returns to IDLE; no frame_done.
REQ-040 rst asserted at block 10 -> all outputs 0 immediately; a new frame_start yields a clean 32-block frame.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared state encoding and default constants for the bf2 sequencer
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int IDX_W             = 5;
   localparam int DEF_N_BLOCKS      = 32;
   localparam int DEF_PIPE_LAT      = 2;
   localparam int DEF_DRAIN_TIMEOUT = 16;

endpackage

// File: rtl/bf2_index_gen.sv
// rtl/bf2_index_gen.sv - per-lane twiddle index arrays for one block, delayed PIPE_LAT cycles
module bf2_index_gen
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic                             valid_in,
   input  logic [IDX_W-1:0]                 blk,
   output logic                             valid_out,
   output logic [DATA_WIDTH-1:0][IDX_W-1:0] idx1,
   output logic [DATA_WIDTH-1:0][IDX_W-1:0] idx2
);

   typedef logic [DATA_WIDTH-1:0][IDX_W-1:0] idx_arr_t;

   idx_arr_t i1_in, i2_in;
   idx_arr_t i1_pipe [PIPE_LAT];
   idx_arr_t i2_pipe [PIPE_LAT];
   logic     v_pipe  [PIPE_LAT];

   // Arrays are zero while invalid so the pipe never carries stale indices.
   always_comb begin
      i1_in = '0;
      i2_in = '0;
      if (valid_in) begin
         for (int k = 0; k < DATA_WIDTH; k++) begin
            i1_in[k] = {blk[1:0], 3'(k >> 1)};
            i2_in[k] = {blk[4:2], 2'(k)};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < PIPE_LAT; s++) begin
            v_pipe[s]  <= 1'b0;
            i1_pipe[s] <= '0;
            i2_pipe[s] <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < PIPE_LAT; s++) begin
            v_pipe[s]  <= 1'b0;
            i1_pipe[s] <= '0;
            i2_pipe[s] <= '0;
         end
      end else begin
         v_pipe[0]  <= valid_in;
         i1_pipe[0] <= i1_in;
         i2_pipe[0] <= i2_in;
         for (int s = 1; s < PIPE_LAT; s++) begin
            v_pipe[s]  <= v_pipe[s-1];
            i1_pipe[s] <= i1_pipe[s-1];
            i2_pipe[s] <= i2_pipe[s-1];
         end
      end
   end

   assign valid_out = v_pipe[PIPE_LAT-1];
   assign idx1      = i1_pipe[PIPE_LAT-1];
   assign idx2      = i2_pipe[PIPE_LAT-1];

endmodule

// File: rtl/bf2_seq_ctrl.sv
// rtl/bf2_seq_ctrl.sv - frame sequencer launching blocks into butterfly stage 2
module bf2_seq_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int N_BLOCKS      = DEF_N_BLOCKS,
   parameter int PIPE_LAT      = DEF_PIPE_LAT,
   parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             frame_start,
   input  logic                             in_valid,
   input  logic                             bf2_o_en,
   output logic                             valid_start_2,
   output logic                             index1_valid,
   output logic                             index2_valid,
   output logic [DATA_WIDTH-1:0][IDX_W-1:0] index1,
   output logic [DATA_WIDTH-1:0][IDX_W-1:0] index2,
   output logic                             busy,
   output logic                             frame_done,
   output logic                             err_protocol,
   output logic                             err_timeout
);

   localparam int BW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
   localparam int OW = $clog2(N_BLOCKS + 1);
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

   state_t          state, state_next;
   logic [BW-1:0]   blk_cnt, launch_blk;
   logic [OW-1:0]   out_cnt, out_cnt_next;
   logic [TW-1:0]   drain_cnt;
   logic            accept, last_blk, out_full, timeout;
   logic            vs_d, err_p_d, busy_d, done_d;
   logic            idx_valid;

   assign accept   = (state == RUN) && in_valid;
   assign last_blk = (blk_cnt == BW'(N_BLOCKS - 1));
   assign out_full = (out_cnt_next == OW'(N_BLOCKS));

   // Returned outputs count in RUN and DRAIN only, saturating at a full frame.
   always_comb begin
      out_cnt_next = out_cnt;
      if ((state == RUN || state == DRAIN) && bf2_o_en && out_cnt != OW'(N_BLOCKS))
         out_cnt_next = out_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      timeout    = 1'b0;
      case (state)
         IDLE:  if (frame_start) state_next = RUN;
         RUN:   if (accept && last_blk) state_next = DRAIN;
         DRAIN: begin
            if (out_full) begin
               state_next = DONE;
            end else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
               state_next = IDLE;
               timeout    = 1'b1;
            end
         end
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      vs_d    = accept;
      err_p_d = (in_valid && state != RUN) || (frame_start && state != IDLE) ||
                (bf2_o_en && state == IDLE);
      busy_d  = (state_next != IDLE);
      done_d  = (state_next == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_cnt       <= '0;
         launch_blk    <= '0;
         out_cnt       <= '0;
         drain_cnt     <= '0;
         valid_start_2 <= 1'b0;
         err_protocol  <= 1'b0;
         err_timeout   <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         if (state == IDLE && frame_start) begin
            blk_cnt <= '0;
            out_cnt <= '0;
         end else begin
            if (accept) blk_cnt <= last_blk ? '0 : blk_cnt + 1'b1;
            out_cnt <= out_cnt_next;
         end
         drain_cnt     <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         launch_blk    <= blk_cnt;
         valid_start_2 <= vs_d;
         err_protocol  <= err_p_d;
         err_timeout   <= timeout;
         busy          <= busy_d;
         frame_done    <= done_d;
      end
   end

   bf2_index_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .PIPE_LAT   (PIPE_LAT)
   ) u_index_gen (
      .clk       (clk),
      .rst       (rst),
      .flush     (timeout),
      .valid_in  (valid_start_2),
      .blk       (IDX_W'(launch_blk)),
      .valid_out (idx_valid),
      .idx1      (index1),
      .idx2      (index2)
   );

   assign index1_valid = idx_valid;
   assign index2_valid = idx_valid;

endmodule

// File: tb/tb_bf2_seq_ctrl.sv
// tb/tb_bf2_seq_ctrl.sv - directed and randomized frames against a frame-level reference model
module tb_bf2_seq_ctrl;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_start, in_valid, bf2_o_en;
   logic             valid_start_2, index1_valid, index2_valid;
   logic [15:0][4:0] index1, index2;
   logic             busy, frame_done, err_protocol, err_timeout;

   bf2_seq_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .frame_start   (frame_start),
      .in_valid      (in_valid),
      .bf2_o_en      (bf2_o_en),
      .valid_start_2 (valid_start_2),
      .index1_valid  (index1_valid),
      .index2_valid  (index2_valid),
      .index1        (index1),
      .index2        (index2),
      .busy          (busy),
      .frame_done    (frame_done),
      .err_protocol  (err_protocol),
      .err_timeout   (err_timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   // frame model: 0 idle, 1 run, 2 drain, 3 done
   int m_phase, m_sent, m_ret, m_dcyc;
   bit e_vs, e_err, e_tmo, e_done, e_busy;
   bit e_launch [int];
   int e_idx_b  [int];
   int st_vs, st_done, st_tmo, last_vs, done_cyc, tmo_cyc;
   int drops;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] idx1_of(input int b);
      logic [79:0] v;
      logic [4:0]  bb;
      bb = b[4:0];
      for (int k = 0; k < 16; k++) v[k*5 +: 5] = {bb[1:0], 3'(k / 2)};
      return v;
   endfunction

   function automatic logic [79:0] idx2_of(input int b);
      logic [79:0] v;
      logic [4:0]  bb;
      bb = b[4:0];
      for (int k = 0; k < 16; k++) v[k*5 +: 5] = {bb[4:2], 2'(k % 4)};
      return v;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_sent = 0; m_ret = 0; m_dcyc = 0;
      e_launch.delete();
      e_idx_b.delete();
   endtask

   // Predicts the outputs of the next cycle from this cycle's inputs.
   task automatic model(input bit fs, input bit iv, input bit oe);
      e_err = (iv && m_phase != 1) || (fs && m_phase != 0) || (oe && m_phase == 0);
      e_vs  = (m_phase == 1) && iv;
      e_tmo = 0;
      if (e_vs) begin
         e_launch[cyc+1] = 1;
         e_idx_b[cyc+3]  = m_sent;
      end
      case (m_phase)
         0: if (fs) begin m_phase = 1; m_sent = 0; m_ret = 0; end
         1: begin
            if (oe && m_ret < 32) m_ret++;
            if (e_vs) begin
               m_sent++;
               if (m_sent == 32) begin m_phase = 2; m_dcyc = 0; end
            end
         end
         2: begin
            if (oe && m_ret < 32) m_ret++;
            m_dcyc++;
            if (m_ret == 32) m_phase = 3;
            else if (m_dcyc == 16) begin m_phase = 0; e_tmo = 1; end
         end
         default: m_phase = 0;
      endcase
      e_done = (m_phase == 3);
      e_busy = (m_phase != 0);
   endtask

   function automatic bit lb();
      return e_launch.exists(cyc - 3);
   endfunction

   task automatic tick(input bit fs, input bit iv, input bit oe);
      bit ie;
      frame_start = fs; in_valid = iv; bf2_o_en = oe;
      model(fs, iv, oe);
      @(posedge clk); #1;
      cyc++;
      ie = e_idx_b.exists(cyc);
      chk("valid_start_2", valid_start_2, e_vs);
      chk("err_protocol", err_protocol, e_err);
      chk("err_timeout", err_timeout, e_tmo);
      chk("frame_done", frame_done, e_done);
      chk("busy", busy, e_busy);
      chk("index1_valid", index1_valid, ie);
      chk("index2_valid", index2_valid, ie);
      chk("index1", index1, ie ? idx1_of(e_idx_b[cyc]) : 80'd0);
      chk("index2", index2, ie ? idx2_of(e_idx_b[cyc]) : 80'd0);
      if (ie && e_idx_b[cyc] == 13) begin
         chk("b13_index1_lane5", index1[5], 5'b01010);
         chk("b13_index2_lane5", index2[5], 5'b01101);
      end
      if (valid_start_2) begin st_vs++; last_vs = cyc; end
      if (frame_done) begin st_done++; done_cyc = cyc; end
      if (err_timeout) begin st_tmo++; tmo_cyc = cyc; end
   endtask

   task automatic stats_clear();
      st_vs = 0; st_done = 0; st_tmo = 0; last_vs = 0; done_cyc = 0; tmo_cyc = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vs"}, valid_start_2, 1'b0);
      chk({tag, "_i1v"}, index1_valid, 1'b0);
      chk({tag, "_i2v"}, index2_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, frame_done, 1'b0);
      chk({tag, "_errp"}, err_protocol, 1'b0);
      chk({tag, "_errt"}, err_timeout, 1'b0);
      chk({tag, "_idx1"}, index1, 80'd0);
      chk({tag, "_idx2"}, index2, 80'd0);
   endtask

   task automatic full_frame(input string tag);
      stats_clear();
      tick(1, 0, 0);
      for (int i = 0; i < 32; i++) tick(0, 1, lb());
      for (int i = 0; i < 12; i++) tick(0, 0, lb());
      chk({tag, "_launches"}, st_vs, 32);
      chk({tag, "_done_count"}, st_done, 1);
   endtask

   initial begin
      int guard;
      bit o;
      rst = 1'b1; frame_start = 0; in_valid = 0; bf2_o_en = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      model_reset();
      tick(0, 0, 0);
      tick(0, 1, 0);
      tick(0, 0, 1);
      tick(0, 0, 0);

      // back-to-back frame with 3-cycle loopback
      full_frame("A");
      chk("A_done_latency", done_cyc - last_vs, 4);

      // gapped frame with 1,0,0,1 pattern, stray frame_start, random gaps
      stats_clear();
      tick(1, 0, 0);
      tick(0, 1, lb()); tick(0, 0, lb()); tick(0, 0, lb()); tick(0, 1, lb());
      chk("B_two_launches", st_vs, 2);
      tick(1, 0, lb());
      guard = 0;
      while (m_sent < 32 && guard < 400) begin
         tick(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), lb());
         guard++;
      end
      for (int i = 0; i < 30; i++) tick(0, ($urandom_range(0, 7) == 0), lb());
      chk("B_launches", st_vs, 32);
      chk("B_done_count", st_done, 1);

      // only 30 returns -> timeout
      stats_clear();
      drops = 2;
      tick(1, 0, 0);
      for (int i = 0; i < 62; i++) begin
         o = lb();
         if (o && drops > 0) begin drops--; o = 0; end
         tick(0, (m_sent < 32), o);
      end
      chk("C_timeout_count", st_tmo, 1);
      chk("C_timeout_latency", tmo_cyc - last_vs, 16);
      chk("C_no_done", st_done, 0);

      // reset mid-frame
      stats_clear();
      tick(1, 0, 0);
      for (int i = 0; i < 10; i++) tick(0, 1, lb());
      frame_start = 0; in_valid = 0; bf2_o_en = 0;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      stats_clear();
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("D_no_done_after_rst", st_done, 0);
      full_frame("D");

      // frame_start together with in_valid in IDLE
      stats_clear();
      tick(1, 1, 0);
      for (int i = 0; i < 32; i++) tick(0, 1, lb());
      for (int i = 0; i < 12; i++) tick(0, 0, lb());
      chk("E_launches", st_vs, 32);
      chk("E_done_count", st_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
